csr_row_expander: RTL and testbench

CSR_ROW_EXPANDER -- requirements
Module: csr_row_expander

---
 rtl/csr_row_expander.sv | 226 ++++++++++++++++++++++
 tb/tb_csr_row_expander.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_row_expander.sv
// Expands a CSR row-pointer stream into packed per-nonzero row ids, EL_PER_DDR lanes per beat.
// Latency: first full beat is valid 3 cycles after the first pointer is accepted; FILL writes up to EL_PER_DDR ids per cycle.
// Backpressure: a presented beat is held stable until m_rid_ready; FILL and pointer fetch stall behind it.
// Optional feature macro: CSR_ROW_EXPANDER_CHECK_EN (decreasing-pointer detection, sticky err).
module csr_row_expander #(
    parameter int EL_PER_DDR = 16,
    parameter int DATA_WIDTH = 32,
    parameter int OFFSET     = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            s_rp_data,
    input  logic                             s_rp_valid,
    output logic                             s_rp_ready,
    input  logic                             s_rp_last,
    output logic [EL_PER_DDR*DATA_WIDTH-1:0] m_rid_data,
    output logic                             m_rid_valid,
    input  logic                             m_rid_ready,
    output logic [EL_PER_DDR-1:0]            m_rid_mask,
    output logic                             m_rid_last,
    output logic                             err
);

    localparam int              LW     = $clog2(EL_PER_DDR + 1);
    localparam logic [LW-1:0]   EL_CNT = LW'(EL_PER_DDR);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FILL,
        FLUSH,
        DONE
    } state_t;

    state_t                                 r_state, w_state;
    logic [DATA_WIDTH-1:0]                  r_prev,  w_prev;
    logic [DATA_WIDTH-1:0]                  r_row,   w_row;
    logic [DATA_WIDTH-1:0]                  r_rem,   w_rem;
    logic                                   r_lflag, w_lflag;
    logic [LW-1:0]                          r_cnt,   w_cnt;
    logic [EL_PER_DDR-1:0][DATA_WIDTH-1:0]  r_data,  w_data;
    logic [EL_PER_DDR-1:0]                  r_mask,  w_mask;
    logic                                   r_vld,   w_vld;
    logic                                   r_olast, w_olast;

    logic                                   w_rdy;
    logic                                   w_out_fire;
    logic [LW-1:0]                          w_free;
    logic [LW-1:0]                          w_take;
    logic [DATA_WIDTH-1:0]                  w_id;
    logic [DATA_WIDTH-1:0]                  w_diff;
    int                                     w_lo;
    int                                     w_hi;

`ifdef CSR_ROW_EXPANDER_CHECK_EN
    logic                                   r_err;
    logic                                   w_err_set;
`endif

    // Next-state and datapath: an accepted beat is retired first so FILL can reuse the lanes in the same cycle.
    always_comb begin
        w_state    = r_state;
        w_prev     = r_prev;
        w_row      = r_row;
        w_rem      = r_rem;
        w_lflag    = r_lflag;
        w_cnt      = r_cnt;
        w_data     = r_data;
        w_mask     = r_mask;
        w_vld      = r_vld;
        w_olast    = r_olast;
        w_rdy      = 1'b0;
`ifdef CSR_ROW_EXPANDER_CHECK_EN
        w_err_set  = 1'b0;
`endif
        w_out_fire = r_vld & m_rid_ready;

        if (w_out_fire) begin
            w_cnt   = '0;
            w_data  = '0;
            w_mask  = '0;
            w_vld   = 1'b0;
            w_olast = 1'b0;
        end

        // Lanes taken this cycle: the rest of the row, capped by the free lanes of the beat.
        w_free = EL_CNT - w_cnt;
        if (r_rem < DATA_WIDTH'(w_free)) begin
            w_take = LW'(r_rem);
        end else begin
            w_take = w_free;
        end
        w_lo   = int'(w_cnt);
        w_hi   = int'(w_cnt) + int'(w_take);
        w_id   = r_row + DATA_WIDTH'(OFFSET);
        w_diff = s_rp_data - r_prev;

        case (r_state)
            IDLE: begin
                w_rdy = 1'b1;
                if (s_rp_valid) begin
                    w_prev  = s_rp_data;
                    w_row   = '0;
                    w_rem   = '0;
                    w_cnt   = '0;
                    w_state = s_rp_last ? FLUSH : FETCH;
                end
            end

            FETCH: begin
                w_rdy = ~r_vld;
                if (s_rp_valid && !r_vld) begin
                    w_rem = w_diff;
`ifdef CSR_ROW_EXPANDER_CHECK_EN
                    if (s_rp_data < r_prev) begin
                        w_rem     = '0;
                        w_err_set = 1'b1;
                    end
`endif
                    w_prev  = s_rp_data;
                    w_lflag = s_rp_last;
                    w_state = FILL;
                end
            end

            FILL: begin
                if (w_cnt == EL_CNT) begin
                    // A full beat that ended exactly on a row boundary is held back until we know
                    // whether more ids follow, so the final beat can carry last without an empty tail beat.
                    if (!w_vld) begin
                        if (r_rem != '0) begin
                            w_vld   = 1'b1;
                            w_olast = 1'b0;
                        end else begin
                            w_row   = r_row + 1'b1;
                            w_state = r_lflag ? FLUSH : FETCH;
                        end
                    end
                end else begin
                    for (int i = 0; i < EL_PER_DDR; i++) begin
                        if ((i >= w_lo) && (i < w_hi)) begin
                            w_data[i] = w_id;
                            w_mask[i] = 1'b1;
                        end
                    end
                    w_cnt = w_cnt + w_take;
                    w_rem = r_rem - DATA_WIDTH'(w_take);
                    if (r_rem == DATA_WIDTH'(w_take)) begin
                        w_row   = r_row + 1'b1;
                        w_state = r_lflag ? FLUSH : FETCH;
                    end else begin
                        // Row continues past this beat, so the beat is full and not the last.
                        w_vld   = 1'b1;
                        w_olast = 1'b0;
                    end
                end
            end

            FLUSH: begin
                if (w_out_fire) begin
                    w_state = DONE;
                end else begin
                    w_vld   = 1'b1;
                    w_olast = 1'b1;
                end
            end

            DONE: begin
                w_state = IDLE;
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset drops any partial beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_prev  <= '0;
            r_row   <= '0;
            r_rem   <= '0;
            r_lflag <= 1'b0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_mask  <= '0;
            r_vld   <= 1'b0;
            r_olast <= 1'b0;
        end else begin
            r_state <= w_state;
            r_prev  <= w_prev;
            r_row   <= w_row;
            r_rem   <= w_rem;
            r_lflag <= w_lflag;
            r_cnt   <= w_cnt;
            r_data  <= w_data;
            r_mask  <= w_mask;
            r_vld   <= w_vld;
            r_olast <= w_olast;
        end
    end

`ifdef CSR_ROW_EXPANDER_CHECK_EN
    // Sticky pointer-order error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_err_set;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign s_rp_ready  = w_rdy & ~rst;
    assign m_rid_data  = r_data;
    assign m_rid_valid = r_vld;
    assign m_rid_mask  = r_mask;
    assign m_rid_last  = r_olast;

endmodule

// File: tb/tb_csr_row_expander.sv
// Bench for csr_row_expander: two instances (OFFSET 0 and 7) share one stimulus stream.
// Expected beats come from flattening the per-row nonzero counts into an id list and chunking it.
// Covers directed cases, reset behaviour, backpressure stability and randomized matrices.
module tb_csr_row_expander;

    localparam int EL = 16;
    localparam int DW = 32;
    localparam int BW = EL * DW;

`ifdef CSR_ROW_EXPANDER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_rp_data = '0;
    logic          s_rp_valid = 1'b0;
    logic          s_rp_last = 1'b0;
    logic          m_rid_ready = 1'b0;

    logic          rdy_a, vld_a, lst_a, err_a;
    logic [BW-1:0] dat_a;
    logic [EL-1:0] msk_a;
    logic          rdy_b, vld_b, lst_b, err_b;
    logic [BW-1:0] dat_b;
    logic [EL-1:0] msk_b;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] exp_d0[$];
    logic [BW-1:0] exp_d7[$];
    logic [BW-1:0] exp_m[$];
    logic [BW-1:0] exp_l[$];
    logic [BW-1:0] got_da[$];
    logic [BW-1:0] got_db[$];
    logic [BW-1:0] got_m[$];
    logic [BW-1:0] got_mb[$];
    logic [BW-1:0] got_l[$];

    always #5 clk = ~clk;

    csr_row_expander #(.EL_PER_DDR(EL), .DATA_WIDTH(DW), .OFFSET(0)) dut_a (
        .clk(clk), .rst(rst),
        .s_rp_data(s_rp_data), .s_rp_valid(s_rp_valid), .s_rp_ready(rdy_a), .s_rp_last(s_rp_last),
        .m_rid_data(dat_a), .m_rid_valid(vld_a), .m_rid_ready(m_rid_ready),
        .m_rid_mask(msk_a), .m_rid_last(lst_a), .err(err_a)
    );

    csr_row_expander #(.EL_PER_DDR(EL), .DATA_WIDTH(DW), .OFFSET(7)) dut_b (
        .clk(clk), .rst(rst),
        .s_rp_data(s_rp_data), .s_rp_valid(s_rp_valid), .s_rp_ready(rdy_b), .s_rp_last(s_rp_last),
        .m_rid_data(dat_b), .m_rid_valid(vld_b), .m_rid_ready(m_rid_ready),
        .m_rid_mask(msk_b), .m_rid_last(lst_b), .err(err_b)
    );

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: each row contributes (next_ptr - ptr) copies of its index; the flat id
    // list is cut into beats of EL lanes, the final beat carries last, and an empty matrix yields one empty beat.
    function automatic void build_expect(input int unsigned p[$]);
        int unsigned ids[$];
        int unsigned cnt;
        int          nb;
        logic [BW-1:0] d0, d7, m;
        exp_d0.delete(); exp_d7.delete(); exp_m.delete(); exp_l.delete();
        for (int r = 0; r + 1 < p.size(); r++) begin
            cnt = (CHECK_EN && (p[r+1] < p[r])) ? 0 : p[r+1] - p[r];
            for (int unsigned k = 0; k < cnt; k++) ids.push_back(r);
        end
        nb = (ids.size() == 0) ? 1 : (ids.size() + EL - 1) / EL;
        for (int b = 0; b < nb; b++) begin
            d0 = '0; d7 = '0; m = '0;
            for (int l = 0; l < EL; l++) begin
                if (b * EL + l < ids.size()) begin
                    d0[l*DW +: DW] = ids[b*EL + l];
                    d7[l*DW +: DW] = ids[b*EL + l] + 7;
                    m[l] = 1'b1;
                end
            end
            exp_d0.push_back(d0);
            exp_d7.push_back(d7);
            exp_m.push_back(m);
            exp_l.push_back(BW'(b == nb - 1));
        end
    endfunction

    // Drives one pointer, waiting a bounded number of cycles for acceptance.
    task automatic send_ptr(input int unsigned v, input bit last, input int gap, output bit to);
        s_rp_valid = 1'b0;
        s_rp_last  = 1'b0;
        repeat ($urandom_range(0, gap)) @(negedge clk);
        s_rp_valid = 1'b1;
        s_rp_data  = v;
        s_rp_last  = last;
        to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            bit r;
            r = rdy_a;
            @(negedge clk);
            if (r) begin
                to = 1'b0;
                break;
            end
        end
        s_rp_valid = 1'b0;
        s_rp_last  = 1'b0;
    endtask

    // mode 0: ready high; mode 1: random ready; mode 2: ready low for the first 5 valid cycles.
    task automatic run_matrix(input string name, input int unsigned p[$], input int mode, input int gap);
        bit            drv_to;
        bit            col_to;
        build_expect(p);
        got_da.delete(); got_db.delete(); got_m.delete(); got_mb.delete(); got_l.delete();
        drv_to = 1'b0;
        col_to = 1'b1;
        fork
            begin
                for (int i = 0; i < p.size(); i++) begin
                    bit t;
                    send_ptr(p[i], i == p.size() - 1, gap, t);
                    if (t) drv_to = 1'b1;
                end
            end
            begin
                int            stallc;
                bit            holding;
                bit            rdy;
                logic [BW-1:0] hold;
                stallc  = 0;
                holding = 1'b0;
                for (int cyc = 0; cyc < 3000; cyc++) begin
                    case (mode)
                        1:       rdy = ($urandom_range(0, 2) != 0);
                        2:       rdy = (stallc >= 5);
                        default: rdy = 1'b1;
                    endcase
                    m_rid_ready = rdy;
                    if (holding) begin
                        chk({name, "_hold_valid"}, BW'(vld_a), BW'(1));
                        chk({name, "_hold_data"}, dat_a, hold);
                        holding = 1'b0;
                    end
                    if (vld_a) begin
                        if (mode == 2) stallc++;
                        if (rdy) begin
                            got_da.push_back(dat_a);
                            got_db.push_back(dat_b);
                            got_m.push_back(BW'(msk_a));
                            got_mb.push_back(BW'(msk_b));
                            got_l.push_back(BW'(lst_a));
                        end else begin
                            hold    = dat_a;
                            holding = 1'b1;
                        end
                    end
                    @(negedge clk);
                    if (got_l.size() > 0 && got_l[got_l.size()-1] == BW'(1)) begin
                        col_to = 1'b0;
                        break;
                    end
                end
            end
        join
        m_rid_ready = 1'b0;
        chk({name, "_drv_timeout"}, BW'(drv_to), '0);
        chk({name, "_col_timeout"}, BW'(col_to), '0);
        chk({name, "_beat_count"}, BW'(got_l.size()), BW'(exp_l.size()));
        for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) begin
            chk($sformatf("%s_b%0d_data", name, i), got_da[i], exp_d0[i]);
            chk($sformatf("%s_b%0d_data_off7", name, i), got_db[i], exp_d7[i]);
            chk($sformatf("%s_b%0d_mask", name, i), got_m[i], exp_m[i]);
            chk($sformatf("%s_b%0d_mask_off7", name, i), got_mb[i], exp_m[i]);
            chk($sformatf("%s_b%0d_last", name, i), got_l[i], exp_l[i]);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, BW'(vld_a), '0);
        chk({tag, "_valid_off7"}, BW'(vld_b), '0);
        chk({tag, "_mask"}, BW'(msk_a), '0);
        chk({tag, "_data"}, dat_a, '0);
        chk({tag, "_last"}, BW'(lst_a), '0);
        chk({tag, "_s_ready"}, BW'(rdy_a), '0);
        chk({tag, "_s_ready_off7"}, BW'(rdy_b), '0);
        chk({tag, "_err"}, BW'(err_a), '0);
    endtask

    initial begin
        int unsigned q[$];
        int unsigned v;
        bit          to;
        bit          saw_vld;
        int          n;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", BW'(rdy_a), BW'(1));

        // Directed matrices.
        q = '{0, 3, 5, 5, 9};   run_matrix("rows_mixed", q, 0, 0);
        q = '{0, 16, 20};       run_matrix("two_beats", q, 1, 1);
        q = '{0, 32};           run_matrix("stall_32", q, 2, 0);
        q = '{0, 0};            run_matrix("nnz_zero", q, 0, 0);
        q = '{0, 2};            run_matrix("two_ids", q, 0, 0);
        q = '{0, 16, 16};       run_matrix("full_then_empty", q, 1, 0);
        q = '{5, 5, 5};         run_matrix("all_empty", q, 0, 1);
        q = '{9};               run_matrix("single_ptr", q, 0, 0);
        q = '{0, 16, 16, 17};   run_matrix("full_empty_one", q, 0, 0);

`ifdef CSR_ROW_EXPANDER_CHECK_EN
        q = '{0, 5, 3, 6};      run_matrix("decreasing", q, 0, 0);
        chk("decreasing_err", BW'(err_a), BW'(1));
`endif

        // Reset mid-matrix: two pointers in, no beat may appear, then a fresh matrix.
        m_rid_ready = 1'b1;
        send_ptr(0, 1'b0, 0, to);
        send_ptr(3, 1'b0, 0, to);
        saw_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (vld_a) saw_vld = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        if (vld_a) saw_vld = 1'b1;
        @(negedge clk);
        reset_checks("mid_reset");
        rst = 1'b0;
        @(negedge clk);
        chk("mid_reset_no_beat", BW'(saw_vld), '0);
        m_rid_ready = 1'b0;
        q = '{0, 1};            run_matrix("after_reset", q, 0, 0);

        // Randomized non-decreasing matrices, biased toward beat-boundary row lengths.
        for (int m = 0; m < 25; m++) begin
            q.delete();
            n = $urandom_range(1, 7);
            v = $urandom_range(0, 50);
            q.push_back(v);
            for (int i = 1; i < n; i++) begin
                case ($urandom_range(0, 5))
                    0:       v = v;
                    1:       v = v + 16;
                    2:       v = v + 1;
                    3:       v = v + 15;
                    4:       v = v + 17;
                    default: v = v + $urandom_range(0, 40);
                endcase
                q.push_back(v);
            end
            run_matrix($sformatf("rnd%0d", m), q, $urandom_range(0, 2), $urandom_range(0, 2));
        end

`ifndef CSR_ROW_EXPANDER_CHECK_EN
        chk("err_tied_low", BW'(err_a), '0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
